jesd204_event_sched: RTL

Schedules single-cycle event requests from up to `NUM_OF_EVENTS` requesters onto a shared LMFC-aligned event output, one event per LMFC edge, with round-robin fairness and a configurable hold-off between issued events. Sits in `jesd204_common` downstream of the clock-domain event synchronizers, on the link clock. It feeds link-layer actions (SYSREF re-arm, lane realign, counter resets) that must occur on an LMFC boundary and never overlap.

---
 rtl/jesd204_event_sched_pkg.sv | 23 ++
 rtl/jesd204_event_sched_if.sv | 31 +++
 rtl/jesd204_rr_arbiter.sv | 57 +++++
 rtl/jesd204_event_sched.sv | 138 +++++++++++++
 4 files changed

// File: rtl/jesd204_event_sched_pkg.sv
// Shared types for the JESD204 LMFC-aligned event scheduler: FSM state
// encoding and the issued-event index width helper.
package jesd204_event_sched_pkg;

    localparam int MAX_EVENTS = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_FIRE    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int id_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/jesd204_event_sched_if.sv
// Request/config/status bundle of the event scheduler; master drives the
// requests and configuration, slave is the scheduler itself.
interface jesd204_event_sched_if
    import jesd204_event_sched_pkg::*;
#(
    parameter int NUM_OF_EVENTS = 4,
    parameter int HOLDOFF_WIDTH = 4
);
    localparam int ID_W = id_width(NUM_OF_EVENTS);

    logic                     lmfc_edge;
    logic [NUM_OF_EVENTS-1:0] in_event;
    logic [NUM_OF_EVENTS-1:0] cfg_event_mask;
    logic [HOLDOFF_WIDTH-1:0] cfg_holdoff;
    logic                     cfg_overflow_clear;
    logic [NUM_OF_EVENTS-1:0] out_event;
    logic [ID_W-1:0]          out_id;
    logic [NUM_OF_EVENTS-1:0] status_pending;
    logic [NUM_OF_EVENTS-1:0] status_overflow;

    modport master (
        output lmfc_edge, in_event, cfg_event_mask, cfg_holdoff, cfg_overflow_clear,
        input  out_event, out_id, status_pending, status_overflow
    );

    modport slave (
        input  lmfc_edge, in_event, cfg_event_mask, cfg_holdoff, cfg_overflow_clear,
        output out_event, out_id, status_pending, status_overflow
    );

endinterface

// File: rtl/jesd204_rr_arbiter.sv
// Round-robin pick over N request bits starting just above the last-granted
// index; the pointer moves to the current pick when advance is high.
module jesd204_rr_arbiter
    import jesd204_event_sched_pkg::*;
#(
    parameter  int N    = 4,
    localparam int ID_W = id_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] last_d;
    logic [ID_W-1:0] idx_s;
    logic            found_s;

    // Scan from last+1 upward with wrap; first pending bit wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found_s  = 1'b0;
        idx_s    = '0;
        for (int k = 1; k <= N; k++) begin
            idx_s = ID_W'((int'(last_q) + k) % N);
            if (!found_s && req[idx_s]) begin
                found_s      = 1'b1;
                grant[idx_s] = 1'b1;
                grant_id     = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    always_comb begin
        if (advance) begin
            last_d = grant_id;
        end else begin
            last_d = last_q;
        end
    end

    // After reset index N-1 counts as last granted, so index 0 goes first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= ID_W'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/jesd204_event_sched.sv
// LMFC-aligned single-event scheduler with round-robin fairness and hold-off.
// Optional feature macro: JESD204_EVENT_SCHED_OVERFLOW_EN (sticky overflow).
module jesd204_event_sched
    import jesd204_event_sched_pkg::*;
#(
    parameter int NUM_OF_EVENTS = 4,
    parameter int HOLDOFF_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    jesd204_event_sched_if.slave  bus
);

    localparam int N    = NUM_OF_EVENTS;
    localparam int ID_W = id_width(N);

    state_t             state_q, state_d;
    logic [N-1:0]       pend_q, pend_d;
    logic [N-1:0]       out_event_q, out_event_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic [HOLDOFF_WIDTH-1:0] cnt_q, cnt_d;

    logic [N-1:0]       issue_s;
    logic [N-1:0]       set_s;
    logic [N-1:0]       req_s;
    logic [N-1:0]       grant_s;
    logic [ID_W-1:0]    grant_id_s;
    logic               advance_s;

    // The issued bit is the registered one-hot shown during FIRE; a new
    // request on that same bit survives because set is OR-ed in afterwards.
    assign issue_s = (state_q == ST_FIRE) ? out_event_q : '0;
    assign set_s   = bus.in_event & bus.cfg_event_mask;
    assign pend_d  = ((pend_q & ~issue_s) | set_s) & bus.cfg_event_mask;
    assign req_s   = pend_q & bus.cfg_event_mask;

    jesd204_rr_arbiter #(.N(N)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (req_s),
        .advance  (advance_s),
        .grant    (grant_s),
        .grant_id (grant_id_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_event_d = '0;
        out_id_d    = '0;
        advance_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_d != '0) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (bus.lmfc_edge && (req_s != '0)) begin
                    state_d     = ST_FIRE;
                    out_event_d = grant_s;
                    out_id_d    = grant_id_s;
                    advance_s   = 1'b1;
                end else if (pend_d == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_FIRE: begin
                if (bus.cfg_holdoff != '0) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = bus.cfg_holdoff - HOLDOFF_WIDTH'(1);
                end else if (pend_d != '0) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - HOLDOFF_WIDTH'(1);
                end else if (pend_d != '0) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            out_event_q <= '0;
            out_id_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            out_event_q <= out_event_d;
            out_id_q    <= out_id_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_event      = out_event_q;
    assign bus.out_id         = out_id_q;
    assign bus.status_pending = pend_q;

`ifdef JESD204_EVENT_SCHED_OVERFLOW_EN
    logic [N-1:0] ovf_q, ovf_d;

    // Set has priority over a simultaneous clear.
    assign ovf_d = (ovf_q & ~{N{bus.cfg_overflow_clear}}) | (set_s & pend_q & ~issue_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.status_overflow = ovf_q;
`else
    logic ovf_clear_unused_s;
    assign ovf_clear_unused_s  = bus.cfg_overflow_clear;
    assign bus.status_overflow = '0;
`endif

endmodule
